// File: rtl/codec_tdm_pkg.sv
// Shared frame geometry for the TDM128 codec interface.
package codec_tdm_pkg;

    localparam int unsigned N_SLOTS    = 4;
    localparam int unsigned SLOT_BITS  = 32;
    localparam int unsigned FRAME_BITS = N_SLOTS * SLOT_BITS;

    typedef logic [6:0] frame_cnt_t;

    localparam frame_cnt_t CNT_LAST = 7'd127;

endpackage

// File: rtl/codec_tdm.sv
// TDM128 codec master: generates bick/lrck, shifts DAC slots out on sdin and
// collects ADC slots from sdout, publishing one complete frame per wrap.
module codec_tdm
    import codec_tdm_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sdout,
    output logic                sdin,
    output logic                bick,
    output logic                lrck,
    output logic                sample_clk,
    input  logic signed [W-1:0] dac0,
    input  logic signed [W-1:0] dac1,
    input  logic signed [W-1:0] dac2,
    input  logic signed [W-1:0] dac3,
    output logic signed [W-1:0] adc0,
    output logic signed [W-1:0] adc1,
    output logic signed [W-1:0] adc2,
    output logic signed [W-1:0] adc3
);

    frame_cnt_t            cnt;
    frame_cnt_t            cnt_nxt;
    logic                  wrap_c;
    logic [FRAME_BITS-1:0] tx_q;
    logic [FRAME_BITS-1:0] rx_q;
    logic [FRAME_BITS-1:0] tx_load;
    logic                  rx_valid;
    logic [W-1:0]          dac    [N_SLOTS];
    logic [W-1:0]          adc_rx [N_SLOTS];
    logic [W-1:0]          adc_q  [N_SLOTS];

    assign dac[0] = dac0;
    assign dac[1] = dac1;
    assign dac[2] = dac2;
    assign dac[3] = dac3;

    assign adc0 = adc_q[0];
    assign adc1 = adc_q[1];
    assign adc2 = adc_q[2];
    assign adc3 = adc_q[3];

    assign cnt_nxt = cnt + 7'd1;
    assign wrap_c  = (cnt == CNT_LAST);

    // Frame bit n is the n-th bit on the wire; samples sit MSB-first at slot start.
    always_comb begin
        tx_load = '0;
        for (int s = 0; s < N_SLOTS; s++) begin
            adc_rx[s] = '0;
            for (int i = 0; i < W; i++) begin
                tx_load[s*SLOT_BITS + i] = dac[s][W-1-i];
                adc_rx[s][W-1-i]         = rx_q[s*SLOT_BITS + i];
            end
        end
    end

    // rx_valid marks that the frame in progress began on a wrap, so its end is publishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bick       <= 1'b0;
            lrck       <= 1'b0;
            sample_clk <= 1'b0;
            sdin       <= 1'b0;
            cnt        <= CNT_LAST;
            tx_q       <= '0;
            rx_q       <= '0;
            rx_valid   <= 1'b0;
            for (int s = 0; s < N_SLOTS; s++) begin
                adc_q[s] <= '0;
            end
        end else begin
            bick <= ~bick;
            if (bick) begin
                cnt        <= cnt_nxt;
                lrck       <= ~cnt_nxt[6];
                sample_clk <= ~cnt_nxt[6];
                if (wrap_c) begin
                    tx_q     <= tx_load;
                    sdin     <= tx_load[0];
                    rx_valid <= 1'b1;
                    if (rx_valid) begin
                        for (int s = 0; s < N_SLOTS; s++) begin
                            adc_q[s] <= adc_rx[s];
                        end
                    end
                end else begin
                    sdin <= tx_q[cnt_nxt];
                end
            end else begin
                rx_q[cnt] <= sdout;
            end
        end
    end

endmodule

// File: tb/tb_codec_tdm.sv
// Scoreboard bench for codec_tdm: random DAC/codec frames, loopback and
// mid-frame reset, checked against a clk-count model of the TDM128 framing.
module tb_codec_tdm;

    localparam int unsigned W = 16;

    typedef logic [3:0][W-1:0] samp4_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                sdout;
    logic                sdin;
    logic                bick;
    logic                lrck;
    logic                sample_clk;
    logic signed [W-1:0] dac0, dac1, dac2, dac3;
    logic signed [W-1:0] adc0, adc1, adc2, adc3;

    logic         loop;
    logic         sdout_drv;
    logic [127:0] codec_cur;
    int           k = 0;

    int vectors     = 0;
    int miscompares = 0;

    samp4_t exp_adc[$];
    logic   exp_bit[$];

    assign sdout = loop ? sdin : sdout_drv;

    codec_tdm #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sdout      (sdout),
        .sdin       (sdin),
        .bick       (bick),
        .lrck       (lrck),
        .sample_clk (sample_clk),
        .dac0       (dac0),
        .dac1       (dac1),
        .dac2       (dac2),
        .dac3       (dac3),
        .adc0       (adc0),
        .adc1       (adc1),
        .adc2       (adc2),
        .adc3       (adc3)
    );

    always #5 clk = ~clk;

    // Posedges since reset release: edge 2 + 256f starts frame f.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    function automatic logic [127:0] pack_frame(input samp4_t v, input logic [127:0] pad);
        logic [127:0] f;
        f = pad;
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < int'(W); i++)
                f[32*s + i] = v[s][W-1-i];
        return f;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at k=%0d: got %h expected %h", name, k, got, exp);
        end
    endtask

    task automatic setup_frame(input int run, input int f);
        samp4_t       d, c;
        logic [127:0] txf;
        logic         lb;
        for (int s = 0; s < 4; s++) begin
            d[s] = W'($urandom);
            c[s] = W'($urandom);
        end
        if (run == 0 && f == 0) begin
            lb = 1'b1;
            d  = {16'h0001, 16'h7FFF, 16'h8000, 16'h1234};
        end else if (run == 0 && f == 1) begin
            lb   = 1'b0;
            d[0] = dac0;
            c[2] = 16'hC000;
        end else begin
            lb = (run == 0) ? (f % 2 == 0) : (f % 2 == 1);
        end
        {dac3, dac2, dac1, dac0} = d;
        loop      = lb;
        txf       = pack_frame(d, '0);
        codec_cur = pack_frame(c, {$urandom, $urandom, $urandom, $urandom});
        for (int n = 0; n < 128; n++) exp_bit.push_back(txf[n]);
        exp_adc.push_back(lb ? d : c);
    endtask

    // Stimulus: frame setup just before each wrap, sdout per bit, dac glitch at count 40.
    initial begin
        int p;
        rst_n     = 1'b0;
        loop      = 1'b0;
        sdout_drv = 1'b0;
        codec_cur = '0;
        {dac3, dac2, dac1, dac0} = '0;
        repeat (4) @(negedge clk);
        for (int run = 0; run < 2; run++) begin
            exp_adc.delete();
            exp_bit.delete();
            exp_adc.push_back('0);
            rst_n = 1'b1;
            while (1) begin
                @(negedge clk);
                if (k % 256 == 1) setup_frame(run, k / 256);
                if (k >= 2) begin
                    p = (k - 2) % 256;
                    if (p % 2 == 0) sdout_drv = codec_cur[p/2];
                    if (p == 80) begin
                        dac0 = (run == 0 && k < 258) ? 16'hABCD : W'($urandom);
                        dac1 = W'($urandom);
                        dac2 = W'($urandom);
                        dac3 = W'($urandom);
                    end
                    if (run == 0 && k == 2 + 256*5 + 141) begin
                        rst_n = 1'b0;
                        loop  = 1'b0;
                        break;
                    end
                end
                if (run == 1 && k == 256*4 + 4) break;
            end
            if (run == 0) repeat (5) @(negedge clk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Monitor: framing every cycle, sdin per bit fall, adc popped at each wrap and held between.
    initial begin
        samp4_t got, e, hold;
        logic   b;
        logic   exp_lr;
        hold = '0;
        forever begin
            @(negedge clk);
            #1;
            got = {adc3, adc2, adc1, adc0};
            if (!rst_n) begin
                hold = '0;
                check("reset_state", 128'({bick, lrck, sample_clk, sdin, got}), 128'(0));
            end else begin
                exp_lr = (k >= 2) && ((k - 2) % 256 < 128);
                check("framing", 128'({bick, lrck, sample_clk}),
                      128'({(k % 2 == 1), exp_lr, exp_lr}));
                if (k >= 2 && k % 2 == 0) begin
                    if (exp_bit.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL sdin_queue at k=%0d: got empty expected entry", k);
                    end else begin
                        b = exp_bit.pop_front();
                        check("sdin_bit", 128'(sdin), 128'(b));
                    end
                end
                if (k >= 2 && (k - 2) % 256 == 0) begin
                    if (exp_adc.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL adc_queue at k=%0d: got empty expected entry", k);
                    end else begin
                        e = exp_adc.pop_front();
                        check("adc_wrap", 128'(got), 128'(e));
                        hold = e;
                    end
                end else begin
                    check("adc_hold", 128'(got), 128'(hold));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish by 1000000");
        $fatal(1);
    end

endmodule

// File: doc/codec_tdm.md
CODEC_TDM -- requirements
Module: codec_tdm

Interface
REQ-001 Parameter W, default 16: sample width in bits.
REQ-002 clk  input  1  system clock (12 MHz); the block has only this one clock.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 sdout  input  1  serial ADC data from codec, TDM128, MSB first.
REQ-005 sdin  output  1  serial DAC data to codec, TDM128, MSB first.
REQ-006 bick  output  1  bit clock to codec, clk/2.
REQ-007 lrck  output  1  frame clock to codec, 50% duty, 128 bick periods.
REQ-008 sample_clk  output  1  frame strobe for the calibrator; identical to lrck.
REQ-009 dac0..dac3  input  W each  signed DAC samples, calibrated-output channels 4..7.
REQ-010 adc0..adc3  output  W each  signed raw ADC samples, calibrator inputs 0..3.

Function
REQ-011 bick SHALL toggle on every clk edge, giving 2 clk per bit and 256 clk per frame (46.875 kHz at 12 MHz).
REQ-012 A 7-bit bit counter SHALL advance on each clk edge where bick falls, wrapping 127->0.
REQ-013 lrck and sample_clk SHALL be high for bit counts 0..63 and low for 64..127, changing on the same edge as the counter.
REQ-014 Frame layout: 4 slots of 32 bits; slot s occupies bits 32s..32s+31; sample left-justified in bits 32s..32s+W-1, MSB first; remaining slot bits SHALL be driven 0 and ignored on receive.
REQ-015 RX: sdout SHALL be sampled on each clk edge where bick rises, into the bit position given by the current count.
REQ-016 On the wrap edge (count 127->0), adc0..adc3 SHALL update from the completed frame; between wraps they SHALL hold.
REQ-017 TX: on the wrap edge, dac0..dac3 SHALL be captured as one 128-bit frame word; dac changes at any other time SHALL NOT affect the frame in flight.
REQ-018 sdin SHALL change only on bick-falling edges; during bit n it carries frame-word bit n, so the slot-0 MSB is driven on the wrap edge itself.
REQ-019 ADC latency: bit 0 of frame k SHALL appear on adc0 at the wrap that ends frame k (frame start + 256 clk).
REQ-020 DAC latency: dac values present at the wrap edge SHALL be on sdin within that same frame.
REQ-021 A valid flag SHALL be cleared by reset and set at the first wrap after a complete 128-bit receive; adc outputs SHALL remain 0 until that flag is set, so no partial frame is published.

Reset
REQ-022 While rst_n is low: bick=0, lrck=0, sample_clk=0, sdin=0, adc0..3=0, count=127, frame word=0, valid flag=0.
REQ-023 The first bick fall after reset release SHALL wrap the count to 0 and start frame 0.
REQ-024 Assertion mid-frame SHALL abort the frame immediately; the partial frame SHALL NOT be published.

Structure
REQ-025 A shared package SHALL hold N_SLOTS=4, SLOT_BITS=32, FRAME_BITS=128, and a frame-count typedef (logic [6:0]).
REQ-026 A single flat module is sufficient; no sub-module is required.

Verification
REQ-027 After reset release, check: bick period 2 clk, lrck/sample_clk period 256 clk with 128 high, first lrck rise one clk after release, adc0..3 held at 0 through the first wrap.
REQ-028 Loopback with sdout tied to sdin, dac0..3=16'h1234, 16'h8000, 16'h7FFF, 16'h0001 -> adc0..3 equal those values by the second wrap, with slot padding bits observed as 0 on sdin.
REQ-029 Changing dac0 from 16'h1234 to 16'hABCD at count 40 -> the current frame still sends 16'h1234; the next frame sends 16'hABCD.
REQ-030 Drive sdout from a codec model sending slot2=16'hC000 -> adc2 = -16384 exactly at the wrap ending that frame and stable for the following 256 clk.
REQ-031 Assert rst_n low at count 70, then release -> all outputs 0, no adc update from the aborted frame, and normal framing restarts per REQ-023.
